// File: rtl/axi4_burst_writer.sv
// axi4_burst_writer
// Turns one command (start address + AXI LEN) plus a stream of data beats
// into a single INCR write burst on the AXI4 AW/W/B channels, then reports
// the slave's BRESP back to the requester as a one-cycle completion pulse.

module axi4_burst_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    // Command request side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    // Write data stream side
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    // Completion report
    output logic                  done_valid,
    output logic [1:0]            done_resp,

    // AXI4 write address channel
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    // AXI4 write data channel
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,

    // AXI4 write response channel
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    // Bytes per beat and the matching AxSIZE encoding; every beat is full width.
    localparam int                  BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int                  SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
    localparam logic [2:0]          BURST_SIZE     = 3'(SIZE_LOG2);
    // Clears the sub-beat byte offset so the burst always starts on a beat boundary.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = {ADDR_WIDTH{1'b1}} << SIZE_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_cmd_ready;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic                    r_awvalid;

    // Nine bits so that a 256-beat burst can count to 256 without wrapping.
    logic [8:0]              r_beats_loaded;

    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_wlast;
    logic                    r_wvalid;

    logic                    r_bready;
    logic                    r_done_valid;
    logic [1:0]              r_done_resp;

    logic                    w_cmd_hs;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_last_hs;
    logic                    w_b_hs;
    logic                    w_more_beats;
    logic                    w_wslot_free;
    logic                    w_wr_data_ready;
    logic                    w_beat_accept;
    logic                    w_beat_is_last;

    // Handshake and beat-accounting decode shared by the FSM and the datapath.
    always_comb begin
        w_cmd_hs        = cmd_valid && r_cmd_ready;
        w_aw_hs         = r_awvalid && AWREADY;
        w_w_hs          = r_wvalid && WREADY;
        w_last_hs       = w_w_hs && r_wlast;
        w_b_hs          = (r_state == RESP) && r_bready && BVALID;
        w_more_beats    = (r_beats_loaded <= {1'b0, r_awlen});
        w_wslot_free    = !r_wvalid || WREADY;
        w_wr_data_ready = (r_state == DATA) && w_more_beats && w_wslot_free;
        w_beat_accept   = wr_data_valid && w_wr_data_ready;
        w_beat_is_last  = (r_beats_loaded == {1'b0, r_awlen});
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one address phase, LEN+1 data beats, one response.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    w_next_state = ADDR;
                end
            end
            ADDR: begin
                if (w_aw_hs) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_last_hs) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered per-state strobes, computed from the upcoming state so they line up with it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cmd_ready <= 1'b0;
            r_bready    <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next_state == IDLE);
            r_bready    <= (w_next_state == RESP);
        end
    end

    // Address channel: capture the command and hold AWVALID until the slave takes it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awvalid <= 1'b0;
        end else if (w_cmd_hs) begin
            r_awaddr  <= cmd_addr & ALIGN_MASK;
            r_awlen   <= cmd_len;
            r_awvalid <= 1'b1;
        end else if (w_aw_hs) begin
            r_awvalid <= 1'b0;
        end
    end

    // Beat counter: restarts as the data phase begins and stops at LEN+1.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_beats_loaded <= '0;
        end else if (w_aw_hs) begin
            r_beats_loaded <= '0;
        end else if (w_beat_accept) begin
            r_beats_loaded <= r_beats_loaded + 9'd1;
        end
    end

    // One-entry W output register: load a new beat whenever the slot is empty or draining.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wdata  <= '0;
            r_wlast  <= 1'b0;
            r_wvalid <= 1'b0;
        end else if (w_beat_accept) begin
            r_wdata  <= wr_data;
            r_wlast  <= w_beat_is_last;
            r_wvalid <= 1'b1;
        end else if (w_w_hs) begin
            r_wlast  <= 1'b0;
            r_wvalid <= 1'b0;
        end
    end

    // Completion: pulse once per response and keep the last BRESP visible afterwards.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_done_valid <= 1'b0;
            r_done_resp  <= 2'b00;
        end else begin
            r_done_valid <= w_b_hs;
            if (w_b_hs) begin
                r_done_resp <= BRESP;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign wr_data_ready = w_wr_data_ready;
    assign done_valid    = r_done_valid;
    assign done_resp     = r_done_resp;
    assign AWADDR        = r_awaddr;
    assign AWLEN         = r_awlen;
    assign AWSIZE        = BURST_SIZE;
    assign AWVALID       = r_awvalid;
    assign WDATA         = r_wdata;
    assign WLAST         = r_wlast;
    assign WVALID        = r_wvalid;
    assign BREADY        = r_bready;

endmodule

// File: tb/tb_axi4_burst_writer.sv
// Testbench for axi4_burst_writer: a small memory-backed AXI slave, a data
// source, and a scoreboard whose monitor checks AW, W and completion traffic
// against expectations queued when each command is issued.

module tb_axi4_burst_writer;

    localparam int DW        = 32;
    localparam int AW        = 16;
    localparam int MEM_WORDS = 1024;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic          wr_data_valid;
    logic          wr_data_ready;
    logic [DW-1:0] wr_data;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;

    always #5 ACLK = ~ACLK;

    axi4_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
        .done_valid(done_valid), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } awExp_t;
    typedef struct { logic [DW-1:0] data; logic last; } wExp_t;

    int            testsRun = 0;
    int            testsFailed = 0;
    logic [DW-1:0] mem [0:MEM_WORDS-1];
    awExp_t        awQ[$];
    wExp_t         wQ[$];
    logic [1:0]    doneQ[$];
    logic [DW-1:0] dataQ[$];
    bit            toggleReady = 0;
    bit            randValid = 0;
    int            wBeatsSeen = 0;
    int            doneSeen = 0;

    // Compare one observed value against the value the bench expects.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: event not as expected", name);
    endtask

    // Slave and data source: sample handshakes mid-cycle, react just after the edge.
    initial begin
        logic          sAw, sW, sB, sD, sWLast;
        logic [AW-1:0] sAwAddr;
        logic [DW-1:0] sWData;
        int            slvWord, slvBeat, idx;
        bit            slvErr, pendingB;
        slvWord = 0; slvBeat = 0; slvErr = 0; pendingB = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
        wr_data_valid = 0; wr_data = '0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
        forever begin
            @(negedge ACLK);
            sAw = AWVALID && AWREADY; sAwAddr = AWADDR;
            sW = WVALID && WREADY;   sWData = WDATA; sWLast = WLAST;
            sB = BVALID && BREADY;
            sD = wr_data_valid && wr_data_ready;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; pendingB = 0;
                wr_data_valid = 0; dataQ.delete();
                continue;
            end
            if (sD && dataQ.size() > 0) void'(dataQ.pop_front());
            if (sAw) begin
                slvWord = int'(sAwAddr >> 2); slvBeat = 0; slvErr = 0;
            end
            if (sW) begin
                idx = slvWord + slvBeat;
                if (idx >= MEM_WORDS) slvErr = 1;
                else mem[idx] = sWData;
                slvBeat++;
                if (sWLast) pendingB = 1;
            end
            if (sB) begin
                BVALID = 0;
            end else if (pendingB && !BVALID) begin
                BVALID = 1; BRESP = slvErr ? 2'b10 : 2'b00; pendingB = 0;
            end
            AWREADY = 1;
            WREADY = toggleReady ? !WREADY : 1'b1;
            wr_data_valid = (dataQ.size() > 0) && (randValid ? ($urandom_range(0, 1) == 1) : 1'b1);
            wr_data = (dataQ.size() > 0) ? dataQ[0] : '0;
        end
    end

    // Monitor: pop and compare expectations whenever the DUT presents a transfer.
    initial begin
        logic          prevDone, stallPending, stallLast;
        logic [DW-1:0] stallData;
        awExp_t        a;
        wExp_t         w;
        logic [1:0]    r;
        prevDone = 0; stallPending = 0; stallLast = 0; stallData = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                stallPending = 0; prevDone = 0;
                continue;
            end
            if (stallPending) begin
                checkOutput("w_stall_valid", WVALID, 1);
                checkOutput("w_stall_data", WDATA, stallData);
                checkOutput("w_stall_last", WLAST, stallLast);
                stallPending = 0;
            end
            if (AWVALID && AWREADY) begin
                if (awQ.size() == 0) reportFail("aw_unexpected");
                else begin
                    a = awQ.pop_front();
                    checkOutput("aw_addr", AWADDR, a.addr);
                    checkOutput("aw_len", AWLEN, a.len);
                    checkOutput("aw_size", AWSIZE, 3'd2);
                end
            end
            if (WVALID && WREADY) begin
                wBeatsSeen++;
                if (wQ.size() == 0) reportFail("w_unexpected");
                else begin
                    w = wQ.pop_front();
                    checkOutput("w_data", WDATA, w.data);
                    checkOutput("w_last", WLAST, w.last);
                end
            end
            if (WVALID && !WREADY) begin
                checkOutput("w_stall_wrready", wr_data_ready, 0);
                stallData = WDATA; stallLast = WLAST; stallPending = 1;
            end
            if (done_valid) begin
                checkOutput("done_pulse_width", prevDone, 0);
                checkOutput("done_cmd_ready", cmd_ready, 1);
                if (doneQ.size() == 0) reportFail("done_unexpected");
                else begin
                    r = doneQ.pop_front();
                    checkOutput("done_resp", done_resp, r);
                end
                doneSeen++;
            end
            prevDone = done_valid;
        end
    end

    // Queue expectations for one burst, feed its data and present the command.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW-1:0] expAddr,
                                 input logic [7:0] len, input logic [DW-1:0] base,
                                 input logic [DW-1:0] step, input logic [1:0] resp);
        awExp_t a;
        wExp_t  w;
        bit     acc;
        a.addr = expAddr; a.len = len;
        awQ.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            w.data = base + step * DW'(i);
            w.last = (i == int'(len));
            wQ.push_back(w);
            dataQ.push_back(w.data);
        end
        doneQ.push_back(resp);
        @(posedge ACLK);
        #1;
        cmd_addr = addr; cmd_len = len; cmd_valid = 1;
        acc = 0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge ACLK);
            if (cmd_ready) acc = 1;
            @(posedge ACLK);
            #1;
        end
        cmd_valid = 0;
        if (!acc) reportFail("cmd_accept_timeout");
    endtask

    task automatic waitDone(input int budget);
        int target;
        target = doneSeen + 1;
        for (int c = 0; c < budget && doneSeen < target; c++) @(posedge ACLK);
        if (doneSeen < target) reportFail("done_timeout");
        @(posedge ACLK);
        #1;
        checkOutput("w_queue_drained", wQ.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startBeats;
        // Reset values while ARESETn is held low
        #12;
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_wr_data_ready", wr_data_ready, 0);
        checkOutput("rst_done_valid", done_valid, 0);
        checkOutput("rst_done_resp", done_resp, 0);
        checkOutput("rst_awvalid", AWVALID, 0);
        checkOutput("rst_awaddr", AWADDR, 0);
        checkOutput("rst_awlen", AWLEN, 0);
        checkOutput("rst_awsize", AWSIZE, 3'd2);
        checkOutput("rst_wvalid", WVALID, 0);
        checkOutput("rst_wdata", WDATA, 0);
        checkOutput("rst_wlast", WLAST, 0);
        checkOutput("rst_bready", BREADY, 0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1;
        #1;
        checkOutput("rel_cmd_ready_before_edge", cmd_ready, 0);
        @(posedge ACLK);
        #1;
        checkOutput("rel_cmd_ready_after_edge", cmd_ready, 1);

        // Single beat
        applyStimulus(16'h0010, 16'h0010, 8'd0, 32'hDEADBEEF, 32'd0, 2'b00);
        waitDone(50);
        checkOutput("mem_single", mem[4], 32'hDEADBEEF);

        // Eight-beat burst, data 0..7
        applyStimulus(16'h0100, 16'h0100, 8'd7, 32'd0, 32'd1, 2'b00);
        waitDone(60);
        for (int i = 0; i < 8; i++) checkOutput("mem_burst8", mem[64 + i], 32'(i));

        // Unaligned start address is truncated to the beat boundary
        applyStimulus(16'h0033, 16'h0030, 8'd1, 32'h55550000, 32'd1, 2'b00);
        waitDone(50);
        checkOutput("mem_unaligned0", mem[12], 32'h55550000);
        checkOutput("mem_unaligned1", mem[13], 32'h55550001);

        // Backpressure: WREADY toggles, data valid random
        toggleReady = 1; randValid = 1;
        applyStimulus(16'h0200, 16'h0200, 8'd15, 32'hA5A50000, 32'd1, 2'b00);
        waitDone(400);
        toggleReady = 0; randValid = 0;
        for (int i = 0; i < 16; i++) checkOutput("mem_backpressure", mem[128 + i], 32'hA5A50000 + 32'(i));

        // Maximum length burst
        startBeats = wBeatsSeen;
        applyStimulus(16'h0000, 16'h0000, 8'd255, 32'h00001000, 32'd1, 2'b00);
        waitDone(700);
        checkOutput("max_beat_count", wBeatsSeen - startBeats, 256);
        checkOutput("mem_max_first", mem[0], 32'h00001000);
        checkOutput("mem_max_last", mem[255], 32'h000010FF);

        // Error response from an out-of-range address, then a clean command
        applyStimulus(16'hFFF0, 16'hFFF0, 8'd3, 32'h000000E0, 32'd1, 2'b10);
        waitDone(60);
        applyStimulus(16'h0040, 16'h0040, 8'd0, 32'h12345678, 32'd0, 2'b00);
        waitDone(50);
        checkOutput("mem_after_err", mem[16], 32'h12345678);

        // Reset in the middle of the data phase
        startBeats = wBeatsSeen;
        applyStimulus(16'h0300, 16'h0300, 8'd3, 32'hC0DE0000, 32'd1, 2'b00);
        for (int c = 0; c < 40 && (wBeatsSeen - startBeats) < 2; c++) @(posedge ACLK);
        if ((wBeatsSeen - startBeats) < 2) reportFail("midreset_beats_timeout");
        #2;
        ARESETn = 0;
        #1;
        checkOutput("midrst_awvalid", AWVALID, 0);
        checkOutput("midrst_wvalid", WVALID, 0);
        checkOutput("midrst_bready", BREADY, 0);
        checkOutput("midrst_cmd_ready", cmd_ready, 0);
        awQ.delete(); wQ.delete(); doneQ.delete(); dataQ.delete();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1;
        @(posedge ACLK);
        #1;
        checkOutput("midrst_cmd_ready_after", cmd_ready, 1);
        applyStimulus(16'h0380, 16'h0380, 8'd3, 32'hBEEF0000, 32'd1, 2'b00);
        waitDone(60);
        for (int i = 0; i < 4; i++) checkOutput("mem_after_reset", mem[224 + i], 32'hBEEF0000 + 32'(i));

        repeat (3) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
